// File: rtl/cla_nibble_sequencer_pkg.sv
// Shared types and sizing helpers for the nibble-serial CLA adder sequencer.
package cla_nibble_sequencer_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int calc_nnib(input int width);
        return width / NIB_W;
    endfunction

    // The index register keeps at least one bit even for a single-nibble build.
    function automatic int calc_idx_w(input int nnib);
        return (nnib > 1) ? $clog2(nnib) : 1;
    endfunction

endpackage

// File: rtl/cla_nibble_sequencer_cla4_slice.sv
// Combinational 4-bit generate/propagate carry-lookahead slice.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       c3,
    output logic       co
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // All carries flattened from g/p so no carry ripples through the slice.
    assign c_s[0] = ci;
    assign c_s[1] = g_s[0] | (p_s[0] & ci);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & ci);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & ci);

    assign s  = p_s ^ c_s[3:0];
    assign c3 = c_s[3];
    assign co = c_s[4];

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder that runs one 4-bit CLA slice over the operands a nibble per clock.
// Defining CLA_SEQ_SUB_EN adds the op port and subtract support (op=1: a - b, cout=1 means no borrow).
module cla_nibble_sequencer
    import cla_nibble_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NNIB  = calc_nnib(WIDTH);
    localparam int IDX_W = calc_idx_w(NNIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] nib_idx_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             last_s;
    logic             sub_s;
    logic [WIDTH-1:0] b_load_s;
    logic             carry_load_s;
    logic [NIB_W-1:0] a_nib_s;
    logic [NIB_W-1:0] b_nib_s;
    logic [NIB_W-1:0] s_nib_s;
    logic             c3_s;
    logic             co_s;

`ifdef CLA_SEQ_SUB_EN
    assign sub_s = op;
`else
    assign sub_s = 1'b0;
`endif

    // Subtraction is a + ~b + 1, so the inversion and forced carry happen at load time.
    assign b_load_s     = sub_s ? ~b : b;
    assign carry_load_s = sub_s ? 1'b1 : cin;

    assign accept_s = in_valid & in_ready_s;
    assign last_s   = (nib_idx_r == LAST_IDX);
    assign a_nib_s  = a_r[{nib_idx_r, 2'b00} +: NIB_W];
    assign b_nib_s  = b_r[{nib_idx_r, 2'b00} +: NIB_W];

    cla4_slice u_slice (
        .a  (a_nib_s),
        .b  (b_nib_s),
        .ci (carry_r),
        .s  (s_nib_s),
        .c3 (c3_s),
        .co (co_s)
    );

    // Handshake decode; in DONE a new request may ride on the consumer's acceptance.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s = 1'b1;
            ST_RUN:  in_ready_s = 1'b0;
            ST_DONE: in_ready_s = out_ready;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, per-nibble sum write-back and final carry/overflow capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            nib_idx_r <= {IDX_W{1'b0}};
            carry_r   <= 1'b0;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            sum_r     <= {WIDTH{1'b0}};
            cout_r    <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        a_r       <= a;
                        b_r       <= b_load_s;
                        carry_r   <= carry_load_s;
                        nib_idx_r <= {IDX_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    sum_r[{nib_idx_r, 2'b00} +: NIB_W] <= s_nib_s;
                    carry_r <= co_s;
                    if (last_s) begin
                        nib_idx_r <= {IDX_W{1'b0}};
                        cout_r    <= co_s;
                        ovf_r     <= c3_s ^ co_s;
                    end else begin
                        nib_idx_r <= nib_idx_r + IDX_W'(1'b1);
                    end
                end
                default: begin
                    nib_idx_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r == ST_RUN);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Scoreboard bench for cla_nibble_sequencer: directed cases plus randomized traffic against an arithmetic model.
module tb_cla_nibble_sequencer;

    localparam int WIDTH = 16;
    localparam int NNIB  = WIDTH / 4;
`ifdef CLA_SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    logic             op_v = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    cla_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
        .op        (op_v),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   seen  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Plain full-width arithmetic; overflow from operand/result sign bits.
    function automatic exp_t model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                   input logic ic, input logic io, input int due);
        exp_t             e;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] bb;
        logic             c0;
        logic             sub;
        sub  = io & SUB_EN;
        bb   = sub ? ~ib : ib;
        c0   = sub ? 1'b1 : ic;
        full = {1'b0, ia} + {1'b0, bb} + {{WIDTH{1'b0}}, c0};
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.ovf  = (ia[WIDTH-1] == bb[WIDTH-1]) && (e.sum[WIDTH-1] != ia[WIDTH-1]);
        e.due  = due;
        return e;
    endfunction

    // One clock of stimulus; an accepted request pushes its expected result.
    task automatic drive(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ic, input logic io, input logic ordy, output logic acc);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
`ifdef CLA_SEQ_SUB_EN
        op_v      = io;
`endif
        out_ready = ordy;
        @(negedge clk);
        acc = iv && in_ready && !rst;
        if (acc) sb.push_back(model(ia, ib, ic, io, cyc + 1 + NNIB));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, ordy, acc);
    endtask

    task automatic send(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic ic, input logic io, input logic ordy);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) drive(1'b1, ia, ib, ic, io, ordy, acc);
        chk("send_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) idle(1, 1'b1);
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Monitor: checks every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else begin
            if (busy) chk("in_ready_run", {31'd0, in_ready}, 32'd0);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got sum %0h with no pending request", sum);
                end else begin
                    if (!seen) begin
                        chk("latency", cyc, sb[0].due);
                        seen = 1'b1;
                    end
                    chk("sum", {16'd0, sum}, {16'd0, sb[0].sum});
                    chk("cout", {31'd0, cout}, {31'd0, sb[0].cout});
                    chk("ovf", {31'd0, ovf}, {31'd0, sb[0].ovf});
                    chk("in_ready_done", {31'd0, in_ready}, {31'd0, out_ready});
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        #1;
        do_reset();

        send(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
        drain();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        drain();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        drain();

        // Backpressure, then accept a new request in the same cycle the result is taken.
        send(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b0);
        idle(NNIB + 5, 1'b0);
        drive(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
        chk("accept_in_done", {31'd0, acc}, 32'd1);
        drain();

        // Reset while nib_idx is 2 discards the operation.
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
        do_reset();
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
        drain();

        // Requests during RUN must be ignored.
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < NNIB - 1; i++) drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0, 1'b1, acc);
        in_valid = 1'b0;
        drain();

`ifdef CLA_SEQ_SUB_EN
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
        drain();
        send(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1);
        drain();
`endif

        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 3) != 0), WIDTH'($urandom), WIDTH'($urandom),
                  1'($urandom), 1'($urandom) & SUB_EN, ($urandom_range(0, 3) != 0), acc);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
